// File: rtl/add4_seq_ctrl.sv
// Sequencing wrapper for an external ripple adder: accepts operand pairs and holds them on the adder.
// After a settle time it captures sum/carry into a valid/ready result port, with an accumulator, overflow flag and op counter.
module add4_seq_ctrl #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept, capture, consume;

  assign accept  = (state == IDLE)   && in_valid;
  assign capture = (state == SETTLE) && (settle_cnt == 4'd0);
  assign consume = (state == DONE)   && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)            state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == 4'd0)  state_nxt = DONE;
      DONE:    if (out_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state alone, so out_ready never reaches in_ready combinationally.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Stage 0: operand latch and settle timer
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a      <= '0;
      add_b      <= '0;
      settle_cnt <= 4'd0;
    end else if (accept) begin
      add_a      <= in_acc ? acc : in_a;
      add_b      <= in_b;
      settle_cnt <= CNT_LOAD;
    end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Stage 1: result capture; acc_clr overrides the capture for acc/ovf only
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum   <= '0;
      out_carry <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      if (capture) begin
        out_sum   <= add_s;
        out_carry <= add_c;
      end
      if (acc_clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (capture) begin
        acc <= add_s;
        ovf <= ovf | add_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          op_cnt <= '0;
    else if (consume) op_cnt <= op_cnt + 1'b1;
  end

endmodule

// File: tb/tb_add4_seq_ctrl.sv
// Self-checking bench for add4_seq_ctrl; models the attached adder and scores results through a queue.
module tb_add4_seq_ctrl;
  localparam int SETTLE_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_acc, acc_clr, out_ready;
  logic [3:0] in_a, in_b;
  logic       in_ready, add_c, out_valid, out_carry, ovf;
  logic [3:0] add_a, add_b, add_s, out_sum, acc;
  logic [7:0] op_cnt;
  logic [4:0] sum5;

  add4_seq_ctrl #(.WIDTH(4), .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .acc(acc), .ovf(ovf), .op_cnt(op_cnt)
  );

  // Behavioural stand-in for the ripple adder
  assign sum5  = {1'b0, add_a} + {1'b0, add_b};
  assign add_s = sum5[3:0];
  assign add_c = sum5[4];

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       accm;
    logic [3:0] s;
    logic       c;
  } vec_t;

  typedef struct {
    logic [3:0] s;
    logic       c;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[10];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] acc_m;
  logic       ovf_m;
  logic [7:0] cnt_m;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume_check();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cnt_m++;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("op_cnt", op_cnt, cnt_m);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic accm,
                        input logic [3:0] es, input logic ec);
    exp_t       e;
    int         n;
    logic [3:0] ea;
    ea = accm ? acc_m : a;
    @(negedge clk);
    in_a = a; in_b = b; in_acc = accm; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    e.s = es; e.c = ec;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; in_acc = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    chk("add_a", add_a, ea);
    chk("add_b", add_b, b);
    wait_valid(n);
    chk("latency", n, SETTLE_CYCLES);
    e = sb.pop_front();
    chk("out_sum", out_sum, e.s);
    chk("out_carry", out_carry, e.c);
    acc_m = e.s;
    ovf_m = ovf_m | e.c;
    chk("acc", acc, acc_m);
    chk("ovf", ovf, ovf_m);
    consume_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_m = 4'd0; ovf_m = 1'b0; cnt_m = 8'd0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         seen;
    exp_t       e;
    logic [3:0] ra, rb;
    logic [4:0] rs;

    vecs[0] = '{a: 4'd4,  b: 4'd3,  accm: 1'b0, s: 4'd7,  c: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  accm: 1'b0, s: 4'd0,  c: 1'b1};
    vecs[2] = '{a: 4'd2,  b: 4'd3,  accm: 1'b0, s: 4'd5,  c: 1'b0};
    vecs[3] = '{a: 4'd7,  b: 4'd0,  accm: 1'b0, s: 4'd7,  c: 1'b0};
    vecs[4] = '{a: 4'd3,  b: 4'd9,  accm: 1'b1, s: 4'd0,  c: 1'b1};
    vecs[5] = '{a: 4'd5,  b: 4'd6,  accm: 1'b1, s: 4'd6,  c: 1'b0};
    vecs[6] = '{a: 4'd10, b: 4'd5,  accm: 1'b0, s: 4'd15, c: 1'b0};
    vecs[7] = '{a: 4'd1,  b: 4'd15, accm: 1'b1, s: 4'd14, c: 1'b1};
    vecs[8] = '{a: 4'd0,  b: 4'd0,  accm: 1'b0, s: 4'd0,  c: 1'b0};
    vecs[9] = '{a: 4'd9,  b: 4'd9,  accm: 1'b0, s: 4'd2,  c: 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    in_a = 4'd0; in_b = 4'd0;
    repeat (3) @(negedge clk);
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_op_cnt", op_cnt, 0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].accm, vecs[i].s, vecs[i].c);

    // Consumer stalls for six cycles: result and handshake must hold.
    @(negedge clk);
    in_a = 4'd1; in_b = 4'd1; in_valid = 1'b1;
    e.s = 4'd2; e.c = 1'b0; sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    chk("stall_latency", n, SETTLE_CYCLES);
    e = sb.pop_front();
    for (int k = 0; k < 6; k++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_sum", out_sum, e.s);
      chk("stall_out_carry", out_carry, e.c);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_add_a", add_a, 1);
      @(negedge clk);
    end
    acc_m = e.s;
    consume_check();

    // Reset one cycle into SETTLE drops the operation.
    @(negedge clk);
    in_a = 4'd5; in_b = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    do_reset();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_add_b", add_b, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_op_cnt", op_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_result", seen, 0);

    // acc_clr on the capture edge of 8+8.
    run_op(4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    in_a = 4'd8; in_b = 4'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (SETTLE_CYCLES - 1) @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("clr_cap_out_valid", out_valid, 1);
    chk("clr_cap_out_sum", out_sum, 0);
    chk("clr_cap_out_carry", out_carry, 1);
    chk("clr_cap_acc", acc, 0);
    chk("clr_cap_ovf", ovf, 0);
    acc_m = 4'd0; ovf_m = 1'b0;
    consume_check();

    // acc_clr with an in_acc accept: operand takes the pre-clear accumulator.
    run_op(4'd3, 4'd4, 1'b0, 4'd7, 1'b0);
    @(negedge clk);
    in_b = 4'd1; in_acc = 1'b1; in_valid = 1'b1; acc_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_acc = 1'b0; acc_clr = 1'b0;
    chk("clr_acc_add_a", add_a, 7);
    chk("clr_acc_acc", acc, 0);
    wait_valid(n);
    chk("clr_acc_out_sum", out_sum, 8);
    chk("clr_acc_out_carry", out_carry, 0);
    acc_m = 4'd8;
    consume_check();

    // 256 operations wrap the counter back to zero.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, 1'b0, rs[3:0], rs[4]);
    end
    chk("op_cnt_wrap", op_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
